// File: rtl/knn_pkg.sv
// Shared types and constants for the K-nearest-neighbour result reader.
// An entry is {group bit, distance}; distance all-ones marks a slot that was never filled.
package knn_pkg;

    localparam int K      = 5;
    localparam int REG_W  = 12;
    localparam int DIST_W = 11;

    localparam logic [DIST_W-1:0] EMPTY_DIST = 11'h7FF;
    localparam logic [2:0]        LAST_IDX   = 3'(K - 1);

    typedef logic [REG_W-1:0] knn_entry_t;

    localparam knn_entry_t EMPTY_ENTRY = '1;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_STREAM = 2'd1,
        RD_RESULT = 2'd2
    } knn_rd_state_t;

    // Emptiness looks only at the distance field; the group bit never takes part.
    function automatic logic entry_is_empty(input knn_entry_t e);
        return e[DIST_W-1:0] == EMPTY_DIST;
    endfunction

endpackage

// File: rtl/knn_vote_tally.sv
// Counts group votes of accepted non-empty entries and keeps a registered majority decision,
// with ties resolved toward the nearest entry's group and an empty query voting group 0.
module knn_vote_tally
    import knn_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_accept,
    input  logic       i_group,
    input  logic       i_empty,
    input  logic       i_nearest_group,
    output logic [2:0] o_votes_g1,
    output logic [2:0] o_votes_total,
    output logic       o_result_group
);

    logic [2:0] r_votes_g1;
    logic [2:0] r_votes_total;
    logic       r_result_group;

    logic [2:0] w_g1_nxt;
    logic [2:0] w_total_nxt;
    logic [3:0] w_twice_g1;
    logic [3:0] w_total_ext;
    logic       w_decision;

    assign w_g1_nxt    = r_votes_g1 + {2'b00, (~i_empty & i_group)};
    assign w_total_nxt = r_votes_total + {2'b00, ~i_empty};
    assign w_twice_g1  = {w_g1_nxt, 1'b0};
    assign w_total_ext = {1'b0, w_total_nxt};

    // Decision is formed from the post-accept counts so it is ready with the last vote.
    always_comb begin
        w_decision = 1'b0;
        if (w_total_nxt == 3'd0)
            w_decision = 1'b0;
        else if (w_twice_g1 > w_total_ext)
            w_decision = 1'b1;
        else if (w_twice_g1 < w_total_ext)
            w_decision = 1'b0;
        else
            w_decision = i_nearest_group;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_votes_g1     <= 3'd0;
            r_votes_total  <= 3'd0;
            r_result_group <= 1'b0;
        end else if (i_clear) begin
            r_votes_g1     <= 3'd0;
            r_votes_total  <= 3'd0;
            r_result_group <= 1'b0;
        end else if (i_accept) begin
            r_votes_g1     <= w_g1_nxt;
            r_votes_total  <= w_total_nxt;
            r_result_group <= w_decision;
        end
    end

    assign o_votes_g1     = r_votes_g1;
    assign o_votes_total  = r_votes_total;
    assign o_result_group = r_result_group;

endmodule

// File: rtl/knn_result_reader.sv
// Snapshots the K nearest entries on a start pulse, streams them nearest-first over valid/ready,
// then presents the vote-based classification. Both ports: a beat transfers when valid & ready; valid holds until then.
module knn_result_reader
    import knn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [K*REG_W-1:0]   i_smallest,
    output logic                 o_busy,
    output logic                 o_entry_valid,
    input  logic                 i_entry_ready,
    output logic [DIST_W-1:0]    o_entry_dist,
    output logic                 o_entry_group,
    output logic [2:0]           o_entry_idx,
    output logic                 o_entry_empty,
    output logic                 o_entry_last,
    output logic                 o_result_valid,
    input  logic                 i_result_ready,
    output logic                 o_result_group,
    output logic [2:0]           o_votes_g1,
    output logic [2:0]           o_votes_total,
    output logic [1:0]           o_dbg_state
);

    knn_rd_state_t     r_state;
    knn_entry_t        r_snap [K];
    logic [2:0]        r_idx;
    logic              r_busy;
    logic              r_entry_valid;
    logic [DIST_W-1:0] r_entry_dist;
    logic              r_entry_group;
    logic              r_entry_empty;
    logic              r_entry_last;
    logic              r_result_valid;

    logic       w_capture;
    logic       w_accept;
    logic [2:0] w_next_idx;
    knn_entry_t w_first;
    knn_entry_t w_next_entry;

    assign w_capture    = (r_state == RD_IDLE) & i_start;
    assign w_accept     = (r_state == RD_STREAM) & r_entry_valid & i_entry_ready;
    assign w_next_idx   = r_idx + 3'd1;
    assign w_first      = i_smallest[REG_W-1:0];
    assign w_next_entry = (r_idx == LAST_IDX) ? r_snap[0] : r_snap[w_next_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= RD_IDLE;
            for (int i = 0; i < K; i++) r_snap[i] <= EMPTY_ENTRY;
            r_idx          <= 3'd0;
            r_busy         <= 1'b0;
            r_entry_valid  <= 1'b0;
            r_entry_dist   <= '0;
            r_entry_group  <= 1'b0;
            r_entry_empty  <= 1'b0;
            r_entry_last   <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                RD_IDLE: begin
                    if (i_start) begin
                        for (int i = 0; i < K; i++) r_snap[i] <= i_smallest[i*REG_W +: REG_W];
                        r_idx         <= 3'd0;
                        r_busy        <= 1'b1;
                        r_entry_valid <= 1'b1;
                        r_entry_dist  <= w_first[DIST_W-1:0];
                        r_entry_group <= w_first[REG_W-1];
                        r_entry_empty <= entry_is_empty(w_first);
                        r_entry_last  <= (LAST_IDX == 3'd0);
                        r_state       <= RD_STREAM;
                    end
                end
                RD_STREAM: begin
                    if (w_accept) begin
                        if (r_idx == LAST_IDX) begin
                            r_entry_valid  <= 1'b0;
                            r_result_valid <= 1'b1;
                            r_state        <= RD_RESULT;
                        end else begin
                            r_idx         <= w_next_idx;
                            r_entry_dist  <= w_next_entry[DIST_W-1:0];
                            r_entry_group <= w_next_entry[REG_W-1];
                            r_entry_empty <= entry_is_empty(w_next_entry);
                            r_entry_last  <= (w_next_idx == LAST_IDX);
                        end
                    end
                end
                RD_RESULT: begin
                    if (i_result_ready) begin
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_state        <= RD_IDLE;
                    end
                end
                default: r_state <= RD_IDLE;
            endcase
        end
    end

    knn_vote_tally u_tally (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_clear         (w_capture),
        .i_accept        (w_accept),
        .i_group         (r_entry_group),
        .i_empty         (r_entry_empty),
        .i_nearest_group (r_snap[0][REG_W-1]),
        .o_votes_g1      (o_votes_g1),
        .o_votes_total   (o_votes_total),
        .o_result_group  (o_result_group)
    );

    assign o_busy         = r_busy;
    assign o_entry_valid  = r_entry_valid;
    assign o_entry_dist   = r_entry_dist;
    assign o_entry_group  = r_entry_group;
    assign o_entry_idx    = r_idx;
    assign o_entry_empty  = r_entry_empty;
    assign o_entry_last   = r_entry_last;
    assign o_result_valid = r_result_valid;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_knn_result_reader.sv
// Directed and randomized queries against a queue-based model of the nearest-first stream and vote result.
module tb_knn_result_reader;
  import knn_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_start = 1'b0;
  logic [K*REG_W-1:0] i_smallest = '0;
  logic               i_entry_ready = 1'b0;
  logic               i_result_ready = 1'b0;
  logic               o_busy, o_entry_valid, o_entry_group, o_entry_empty, o_entry_last;
  logic               o_result_valid, o_result_group;
  logic [DIST_W-1:0]  o_entry_dist;
  logic [2:0]         o_entry_idx, o_votes_g1, o_votes_total;
  logic [1:0]         o_dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  logic [16:0] exp_q[$];
  logic        exp_group;
  logic [2:0]  exp_g1, exp_total;

  knn_result_reader dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_smallest(i_smallest),
    .o_busy(o_busy), .o_entry_valid(o_entry_valid), .i_entry_ready(i_entry_ready),
    .o_entry_dist(o_entry_dist), .o_entry_group(o_entry_group), .o_entry_idx(o_entry_idx),
    .o_entry_empty(o_entry_empty), .o_entry_last(o_entry_last),
    .o_result_valid(o_result_valid), .i_result_ready(i_result_ready),
    .o_result_group(o_result_group), .o_votes_g1(o_votes_g1), .o_votes_total(o_votes_total),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [K*REG_W-1:0] pack5(input logic [11:0] e0, e1, e2, e3, e4);
    return {e4, e3, e2, e1, e0};
  endfunction

  // reference model: expected stream records {idx, last, empty, group, dist} and vote result
  task automatic build_model(input logic [K*REG_W-1:0] d);
    int tot;
    int g1;
    logic [11:0] e;
    logic emp;
    tot = 0;
    g1 = 0;
    exp_q.delete();
    for (int i = 0; i < K; i++) begin
      e = d[i*REG_W +: REG_W];
      emp = (e[10:0] == 11'h7FF);
      if (!emp) begin
        tot++;
        if (e[11]) g1++;
      end
      exp_q.push_back({3'(i), 1'(i == K - 1), emp, e[11], e[10:0]});
    end
    if (tot == 0)          exp_group = 1'b0;
    else if (2 * g1 > tot) exp_group = 1'b1;
    else if (2 * g1 < tot) exp_group = 1'b0;
    else                   exp_group = d[11];
    exp_g1 = 3'(g1);
    exp_total = 3'(tot);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_entry_valid"}, 32'(o_entry_valid), 32'd0);
    check({tag, "_entry_fields"},
          32'({o_entry_idx, o_entry_last, o_entry_empty, o_entry_group, o_entry_dist}), 32'd0);
    check({tag, "_result_valid"}, 32'(o_result_valid), 32'd0);
    check({tag, "_result_group"}, 32'(o_result_group), 32'd0);
    check({tag, "_votes"}, 32'({o_votes_g1, o_votes_total}), 32'd0);
  endtask

  // mode 0: ready held high; 1: ready pattern 1-0-0-1; 2: random ready
  task automatic run_query(input logic [K*REG_W-1:0] d, input int mode, input bit chk_lat,
                           input bit inject);
    int cyc;
    bit stall_prev;
    bit rdy;
    logic [16:0] prev, fields, e;
    logic [K*REG_W-1:0] alt;
    alt = ~d;
    build_model(d);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_smallest = d;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_smallest = alt;
    cyc = 0;
    stall_prev = 1'b0;
    prev = '0;
    while (!o_result_valid && cyc < 200) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_entry_ready = rdy;
      i_start = inject && (cyc == 2);
      @(negedge clk);
      cyc++;
      check("stream_busy", 32'(o_busy), 32'd1);
      check("stream_valid", 32'(o_entry_valid), 32'd1);
      if (o_entry_valid) begin
        fields = {o_entry_idx, o_entry_last, o_entry_empty, o_entry_group, o_entry_dist};
        if (stall_prev) check("stall_hold", 32'(fields), 32'(prev));
        if (i_entry_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_entry", 32'(fields), 32'h1FFFF);
          end else begin
            e = exp_q.pop_front();
            check("entry", 32'(fields), 32'(e));
          end
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          prev = fields;
        end
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    i_entry_ready = 1'b0;
    check("stream_done", 32'(o_result_valid), 32'd1);
    check("entries_left", 32'(exp_q.size()), 32'd0);
    if (chk_lat) check("latency", 32'(cyc + 1), 32'(K + 1));
    repeat (inject ? 2 : $urandom_range(0, 2)) begin
      i_start = inject;
      i_smallest = alt;
      @(negedge clk);
      check("result_hold_valid", 32'(o_result_valid), 32'd1);
      check("result_hold_group", 32'(o_result_group), 32'(exp_group));
      @(posedge clk); #1;
    end
    i_result_ready = 1'b1;
    i_start = inject;
    @(negedge clk);
    check("result_valid", 32'(o_result_valid), 32'd1);
    check("result_group", 32'(o_result_group), 32'(exp_group));
    check("votes_g1", 32'(o_votes_g1), 32'(exp_g1));
    check("votes_total", 32'(o_votes_total), 32'(exp_total));
    check("result_busy", 32'(o_busy), 32'd1);
    @(posedge clk); #1;
    i_result_ready = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    check("after_valid", 32'(o_result_valid), 32'd0);
    check("after_busy", 32'(o_busy), 32'd0);
    check("after_no_capture", 32'(o_entry_valid), 32'd0);
    check("after_state", 32'(o_dbg_state), 32'(RD_IDLE));
    check("votes_hold", 32'({o_votes_g1, o_votes_total}), 32'({exp_g1, exp_total}));
  endtask

  initial begin
    logic [K*REG_W-1:0] d1, d3, d4, rnd;
    logic [11:0] e;
    d1 = pack5(12'h005, 12'h80A, 12'h010, 12'h812, 12'h015);
    d3 = pack5(12'h803, 12'h004, 12'h808, 12'h7FF, 12'h7FF);
    d4 = pack5(12'h801, 12'h002, 12'hFFF, 12'h7FF, 12'h7FF);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check("reset_state", 32'(o_dbg_state), 32'(RD_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_query(d1, 0, 1'b1, 1'b0);
    run_query(d1, 1, 1'b0, 1'b0);
    run_query(d3, 0, 1'b1, 1'b0);
    run_query(d4, 2, 1'b0, 1'b0);
    run_query(pack5(12'h7FF, 12'hFFF, 12'h7FF, 12'hFFF, 12'h7FF), 0, 1'b1, 1'b0);
    run_query(d1, 2, 1'b0, 1'b1);
    run_query(d3, 0, 1'b1, 1'b0);

    for (int q = 0; q < 8; q++) begin
      for (int i = 0; i < K; i++) begin
        e[11] = 1'($urandom_range(0, 1));
        e[10:0] = ($urandom_range(0, 3) == 0) ? 11'h7FF : 11'($urandom_range(0, 2046));
        rnd[i*REG_W +: REG_W] = e;
      end
      run_query(rnd, 2, 1'b0, (q % 3) == 1);
    end

    // reset in the middle of a stream, with rank 2 on the port
    @(posedge clk); #1;
    i_start = 1'b1;
    i_smallest = d1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_entry_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_idx", 32'(o_entry_idx), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    i_entry_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_result", 32'(o_result_valid), 32'd0);
      check("post_reset_busy", 32'(o_busy), 32'd0);
      check("post_reset_entry", 32'(o_entry_valid), 32'd0);
    end
    run_query(d1, 0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
